// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Imported by the interface, the picker and the top.
package regfile_write_arbiter_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

    localparam logic [7:0] ZD_SAT = 8'd255;

    typedef logic [2:0] req_idx_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bundle between the execution units and the arbiter.
// The arbiter is the slave side; it also publishes the registered write port.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
);

    logic                 Hold;
    logic [NREQ-1:0]      ReqValid;
    logic [NREQ*AW-1:0]   ReqReg;
    logic [NREQ*DW-1:0]   ReqData;
    logic [NREQ-1:0]      ReqReady;

    logic                 WriteEn;
    logic [AW-1:0]        WriteReg;
    logic [DW-1:0]        wd3;
    req_idx_t             GrantId;
    logic [7:0]           ZeroDrops;

    modport master (
        output Hold, ReqValid, ReqReg, ReqData,
        input  ReqReady, WriteEn, WriteReg, wd3,
        input  GrantId, ZeroDrops
    );

    modport slave (
        input  Hold, ReqValid, ReqReg, ReqData,
        output ReqReady, WriteEn, WriteReg, wd3,
        output GrantId, ZeroDrops
    );

endinterface

// File: rtl/regfile_write_arbiter_picker.sv
// Round-robin priority picker: first set request bit at or after ptr,
// wrapping modulo NREQ, returned as a one-hot grant.
module rr_priority_picker
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] grant
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-back arbiter in front of a single register-file port.
// Writes to x0 complete the handshake but are dropped and counted.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic                   Clock,
    input  logic                   R,
    regfile_write_arbiter_if.slave bus
);

    req_idx_t        ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wreg_q, wreg_d;
    logic [DW-1:0]   wd_q, wd_d;
    req_idx_t        gid_q, gid_d;
    logic [7:0]      zd_q, zd_d;

    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] ready;
    logic            xfer;
    req_idx_t        k;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;

    rr_priority_picker #(.NREQ(NREQ)) u_picker (
        .req   (bus.ReqValid),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Reset and stall both mask the grant before it leaves the block.
    assign ready        = (R || bus.Hold) ? '0 : pick;
    assign xfer         = |ready;
    assign bus.ReqReady = ready;

    always_comb begin
        k        = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                k        = req_idx_t'(i);
                sel_reg  = bus.ReqReg[AW*i +: AW];
                sel_data = bus.ReqData[DW*i +: DW];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        wreg_d = wreg_q;
        wd_d   = wd_q;
        gid_d  = gid_q;
        zd_d   = zd_q;
        if (xfer) begin
            if (int'(k) == NREQ - 1) ptr_d = '0;
            else                     ptr_d = k + 3'd1;
            if (sel_reg == '0) begin
                if (zd_q != ZD_SAT) zd_d = zd_q + 8'd1;
            end else begin
                we_d   = 1'b1;
                wreg_d = sel_reg;
                wd_d   = sel_data;
                gid_d  = k;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (R) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            wreg_q <= '0;
            wd_q   <= '0;
            gid_q  <= '0;
            zd_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            wreg_q <= wreg_d;
            wd_q   <= wd_d;
            gid_q  <= gid_d;
            zd_q   <= zd_d;
        end
    end

    assign bus.WriteEn   = we_q;
    assign bus.WriteReg  = wreg_q;
    assign bus.wd3       = wd_q;
    assign bus.GrantId   = gid_q;
    assign bus.ZeroDrops = zd_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural arbiter/regfile model.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic Clock = 1'b0;
    logic R     = 1'b1;

    always #5 Clock = ~Clock;

    regfile_write_arbiter_if #(.NREQ(N), .DW(DW), .AW(AW)) bus ();

    regfile_write_arbiter #(.NREQ(N), .DW(DW), .AW(AW)) dut (
        .Clock (Clock),
        .R     (R),
        .bus   (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    logic          d_r;
    logic          d_hold;
    logic [N-1:0]  d_v;
    logic [AW-1:0] d_reg  [N];
    logic [DW-1:0] d_data [N];

    int            m_ptr;
    logic          m_valid = 1'b0;
    logic          m_we;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wd;
    int            m_gid;
    int            m_zd;

    logic [N-1:0]  s_rdy;
    logic          s_we;
    logic [AW-1:0] s_wreg;
    logic [DW-1:0] s_wd;
    logic [2:0]    s_gid;
    logic [7:0]    s_zd;

    logic [DW-1:0] rf [32];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        if (d_r || d_hold) return g;
        for (int i = 0; i < N; i++) begin
            int j = (m_ptr + i) % N;
            if (d_v[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic cycle();
        logic [N-1:0] er;
        int           w;
        @(negedge Clock);
        R           = d_r;
        bus.Hold    = d_hold;
        bus.ReqValid = d_v;
        for (int i = 0; i < N; i++) begin
            bus.ReqReg[AW*i +: AW]  = d_reg[i];
            bus.ReqData[DW*i +: DW] = d_data[i];
        end
        #1;
        er     = model_grant();
        s_rdy  = bus.ReqReady;
        s_we   = bus.WriteEn;
        s_wreg = bus.WriteReg;
        s_wd   = bus.wd3;
        s_gid  = bus.GrantId;
        s_zd   = bus.ZeroDrops;
        chk("ReqReady", 32'(s_rdy), 32'(er));
        if (m_valid) begin
            chk("WriteEn", 32'(s_we), 32'(m_we));
            chk("WriteReg", 32'(s_wreg), 32'(m_wreg));
            chk("wd3", s_wd, m_wd);
            chk("GrantId", 32'(s_gid), 32'(m_gid));
            chk("ZeroDrops", 32'(s_zd), 32'(m_zd));
        end
        if (m_valid && s_we === 1'b1) rf[s_wreg] = s_wd;
        @(posedge Clock);
        if (d_r) begin
            m_valid = 1'b1;
            m_ptr = 0; m_we = 1'b0; m_wreg = '0;
            m_wd = '0; m_gid = 0; m_zd = 0;
        end else if (er != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (er[i]) w = i;
            m_ptr = (w + 1) % N;
            if (d_reg[w] == '0) begin
                m_we = 1'b0;
                if (m_zd < 255) m_zd++;
            end else begin
                m_we = 1'b1;
                m_wreg = d_reg[w];
                m_wd = d_data[w];
                m_gid = w;
            end
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic do_reset();
        d_r = 1'b1;
        d_hold = 1'b0;
        d_v = '0;
        cycle();
        d_r = 1'b0;
    endtask

    logic [N-1:0] one;

    initial begin
        one = 3'b001;
        d_r = 1'b1; d_hold = 1'b0; d_v = '0;
        for (int i = 0; i < N; i++) begin
            d_reg[i] = AW'(i + 1);
            d_data[i] = 32'h100 + i;
        end
        for (int i = 0; i < 32; i++) rf[i] = '0;

        do_reset();
        do_reset();
        chk("rst_we", 32'(s_we), 32'd0);
        chk("rst_zd", 32'(s_zd), 32'd0);

        // single requester, reg 7
        d_v = 3'b010; d_reg[1] = 5'd7; d_data[1] = 32'hDEADBEEF;
        cycle();
        chk("r032_rdy", 32'(s_rdy), 32'b010);
        d_v = '0;
        cycle();
        chk("r032_we", 32'(s_we), 32'd1);
        chk("r032_reg", 32'(s_wreg), 32'd7);
        chk("r032_wd", s_wd, 32'hDEADBEEF);
        chk("r032_gid", 32'(s_gid), 32'd1);

        // all valid from reset: 0,1,2,0,1,2
        do_reset();
        d_v = 3'b111;
        for (int i = 0; i < N; i++) d_reg[i] = AW'(10 + i);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("r033_order", 32'(s_rdy), 32'(one << (i % 3)));
            if (i >= 1) chk("r033_we", 32'(s_we), 32'd1);
        end

        // hold with all valid
        cycle();
        d_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("r036_rdy", 32'(s_rdy), 32'd0);
            if (i >= 1) chk("r036_we", 32'(s_we), 32'd0);
        end
        d_hold = 1'b0;
        cycle();
        chk("r036_resume", 32'(s_rdy), 32'b010);

        // same-register collision
        do_reset();
        rf[5] = '0;
        d_v = 3'b101;
        d_reg[0] = 5'd5; d_data[0] = 32'h11;
        d_reg[2] = 5'd5; d_data[2] = 32'h22;
        cycle();
        chk("r034_first", 32'(s_rdy), 32'b001);
        d_v = 3'b100;
        cycle();
        chk("r034_second", 32'(s_rdy), 32'b100);
        chk("r034_mid", rf[5], 32'h11);
        d_v = '0;
        cycle();
        cycle();
        chk("r034_final", rf[5], 32'h22);

        // writes to x0
        do_reset();
        d_v = 3'b001; d_reg[0] = '0; d_data[0] = 32'h55;
        for (int i = 0; i < 3; i++) cycle();
        d_v = '0;
        cycle();
        chk("r035_we", 32'(s_we), 32'd0);
        chk("r035_zd3", 32'(s_zd), 32'd3);
        d_v = 3'b011; d_reg[1] = 5'd9;
        cycle();
        chk("r035_ptr", 32'(s_rdy), 32'b010);
        d_v = 3'b001;
        for (int i = 0; i < 297; i++) cycle();
        d_v = '0;
        cycle();
        chk("r035_sat", 32'(s_zd), 32'd255);

        // reset coinciding with a grant to requester 2
        do_reset();
        d_reg[0] = '0; d_reg[1] = 5'd3; d_reg[2] = 5'd4;
        d_v = 3'b011;
        cycle();
        cycle();
        d_v = 3'b100; d_r = 1'b1;
        cycle();
        chk("r037_rdy", 32'(s_rdy), 32'd0);
        d_r = 1'b0; d_v = '0;
        cycle();
        chk("r037_we", 32'(s_we), 32'd0);
        chk("r037_zd", 32'(s_zd), 32'd0);
        d_v = 3'b111;
        cycle();
        chk("r037_ptr", 32'(s_rdy), 32'b001);

        // random traffic; pending requests stay stable until granted
        d_v = '0;
        for (int c = 0; c < 500; c++) begin
            d_r = ($urandom_range(0, 49) == 0);
            d_hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!d_v[i] || s_rdy[i]) begin
                    d_v[i] = ($urandom_range(0, 2) != 0);
                    d_reg[i] = ($urandom_range(0, 3) == 0) ?
                               '0 : AW'($urandom_range(1, 31));
                    d_data[i] = $urandom;
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
